// File: rtl/base_address_wr.sv
// Writer end of the PS<->PL BRAM mailbox: streams NUM_WORDS payload words into a BRAM port
// at consecutive byte addresses, then writes a completion flag word for the PS to poll.
module base_address_wr #(
    parameter logic [31:0] START_ADDR = 32'h4580_0000,
    parameter int          NUM_WORDS  = 16,
    parameter logic [31:0] FLAG_VALUE = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ram_clk,
    output logic        ram_rst,
    output logic [31:0] ram_addr,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [31:0] ram_wd_data,
    input  logic [31:0] ram_rd_data,
    input  logic        start,
    input  logic [31:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic        busy,
    output logic        Transfer_Done
);

    localparam int            CW        = $clog2(NUM_WORDS + 1);
    localparam logic [CW-1:0] LAST_IDX  = CW'(NUM_WORDS - 1);
    localparam logic [31:0]   FLAG_ADDR = START_ADDR + (32'(NUM_WORDS) << 2);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        FLAG,
        COMMIT,
        DONE
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [31:0]   addr_reg, addr_next;
    logic [31:0]   data_reg, data_next;
    logic          en_reg, en_next;
    logic [3:0]    we_reg, we_next;
    logic          accept;

    // The read port exists only so the BRAM port bundle is complete.
    logic unused_rd;
    assign unused_rd = ^ram_rd_data;

    assign accept = wr_valid && (state_reg == WRITE);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;
        en_next    = 1'b0;
        we_next    = 4'h0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next = WRITE;
                    cnt_next   = '0;
                end
            end
            WRITE: begin
                if (accept) begin
                    cnt_next  = cnt_reg + CW'(1);
                    en_next   = 1'b1;
                    we_next   = 4'hF;
                    addr_next = START_ADDR + (32'(cnt_reg) << 2);
                    data_next = wr_data;
                    if (cnt_reg == LAST_IDX) begin
                        state_next = FLAG;
                    end
                end
            end
            FLAG: begin
                state_next = COMMIT;
                en_next    = 1'b1;
                we_next    = 4'hF;
                addr_next  = FLAG_ADDR;
                data_next  = FLAG_VALUE;
            end
            COMMIT: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            data_reg  <= '0;
            en_reg    <= 1'b0;
            we_reg    <= 4'h0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
            en_reg    <= en_next;
            we_reg    <= we_next;
        end
    end

    assign ram_clk       = clk;
    assign ram_rst       = 1'b0;
    assign ram_addr      = addr_reg;
    assign ram_en        = en_reg;
    assign ram_we        = we_reg;
    assign ram_wd_data   = data_reg;
    assign wr_ready      = (state_reg == WRITE);
    assign busy          = (state_reg == WRITE) || (state_reg == FLAG) || (state_reg == COMMIT);
    assign Transfer_Done = (state_reg == DONE);

endmodule

// File: tb/tb_base_address_wr.sv
// Bench for base_address_wr: three instances (4 words, 1 word, wrapping address), writes
// observed on the port are compared against an expected-write queue.
module tb_base_address_wr;

    localparam logic [31:0] BASE_A = 32'h4580_0000;
    localparam logic [31:0] BASE_W = 32'hFFFF_FFF8;
    localparam logic [31:0] FLAG_A = 32'h0000_0001;
    localparam logic [31:0] FLAG_B = 32'h5A5A_0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  start_vec;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic [31:0] rd_data = 32'h0;

    logic        ram_clk_o [3];
    logic        ram_rst_o [3];
    logic        en_o      [3];
    logic        ready_o   [3];
    logic        busy_o    [3];
    logic        done_o    [3];
    logic [31:0] addr_o    [3];
    logic [31:0] wd_o      [3];
    logic [3:0]  we_o      [3];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  we;
        int          cyc;
    } wr_t;

    wr_t exp_q[$];
    wr_t obs_q[$];
    int  obs_rd = 0;
    int  cyc = 0;
    int  bad_we = 0;
    int  sel = 0;
    int  errors = 0;
    int  checks = 0;

    always #5 clk = ~clk;

    base_address_wr #(.START_ADDR(BASE_A), .NUM_WORDS(4), .FLAG_VALUE(FLAG_A)) u_n4 (
        .clk(clk), .rst_n(rst_n), .ram_clk(ram_clk_o[0]), .ram_rst(ram_rst_o[0]),
        .ram_addr(addr_o[0]), .ram_en(en_o[0]), .ram_we(we_o[0]), .ram_wd_data(wd_o[0]),
        .ram_rd_data(rd_data), .start(start_vec[0]), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(ready_o[0]), .busy(busy_o[0]), .Transfer_Done(done_o[0])
    );

    base_address_wr #(.START_ADDR(BASE_A), .NUM_WORDS(1), .FLAG_VALUE(FLAG_B)) u_n1 (
        .clk(clk), .rst_n(rst_n), .ram_clk(ram_clk_o[1]), .ram_rst(ram_rst_o[1]),
        .ram_addr(addr_o[1]), .ram_en(en_o[1]), .ram_we(we_o[1]), .ram_wd_data(wd_o[1]),
        .ram_rd_data(rd_data), .start(start_vec[1]), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(ready_o[1]), .busy(busy_o[1]), .Transfer_Done(done_o[1])
    );

    base_address_wr #(.START_ADDR(BASE_W), .NUM_WORDS(2), .FLAG_VALUE(FLAG_B)) u_wrap (
        .clk(clk), .rst_n(rst_n), .ram_clk(ram_clk_o[2]), .ram_rst(ram_rst_o[2]),
        .ram_addr(addr_o[2]), .ram_en(en_o[2]), .ram_we(we_o[2]), .ram_wd_data(wd_o[2]),
        .ram_rd_data(rd_data), .start(start_vec[2]), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(ready_o[2]), .busy(busy_o[2]), .Transfer_Done(done_o[2])
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write the selected instance puts on its port, stamped with the edge count.
    always @(negedge clk) begin
        if (en_o[sel] === 1'b1) begin
            obs_q.push_back('{addr_o[sel], wd_o[sel], we_o[sel], cyc});
        end else if (we_o[sel] !== 4'h0) begin
            bad_we <= bad_we + 1;
        end
    end

    // Drives one transfer on the selected instance and pushes the writes it must produce.
    task automatic drive_transfer(input int n, input logic [31:0] base, input logic [31:0] flagv,
                                  input logic [7:0] d0, input bit gap, input bit hold_start,
                                  output int s_edge, output int last_edge,
                                  output logic done_after_start);
        int words = 0;
        int k = 0;
        last_edge = 0;
        done_after_start = 1'bx;
        @(negedge clk);
        start_vec[sel] = 1'b1;
        wr_valid = 1'b0;
        s_edge = cyc + 1;
        while (words < n && k < 1000) begin
            @(negedge clk);
            if (!hold_start) start_vec[sel] = 1'b0;
            if (k == 0) done_after_start = done_o[sel];
            wr_valid = gap ? (k % 3 == 0) : 1'b1;
            if (wr_valid) begin
                wr_data = 32'(d0) + 32'(words);
                exp_q.push_back('{base + 32'(words) * 32'd4, wr_data, 4'hF, cyc + 1});
                last_edge = cyc + 1;
                words++;
            end
            k++;
        end
        @(negedge clk);
        wr_valid = 1'b0;
        start_vec[sel] = 1'b0;
        exp_q.push_back('{base + 32'(n) * 32'd4, flagv, 4'hF, last_edge + 1});
    endtask

    task automatic test_reset();
        int n0;
        int s, last, dcyc;
        logic das;
        rst_n = 1'b0; start_vec = 3'b000; wr_valid = 1'b0; wr_data = 32'h0; sel = 0;
        #23;
        checks++; if (addr_o[0] !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", addr_o[0]); end
        checks++; if (en_o[0] !== 1'b0) begin errors++; $display("FAIL reset_en got=%b exp=0", en_o[0]); end
        checks++; if (we_o[0] !== 4'h0) begin errors++; $display("FAIL reset_we got=%h exp=0", we_o[0]); end
        checks++; if (wd_o[0] !== 32'h0) begin errors++; $display("FAIL reset_wd got=%h exp=0", wd_o[0]); end
        checks++; if (done_o[0] !== 1'b0 || busy_o[0] !== 1'b0 || ready_o[0] !== 1'b0) begin
            errors++; $display("FAIL reset_status got done=%b busy=%b ready=%b exp=0", done_o[0], busy_o[0], ready_o[0]);
        end
        checks++; if (ram_rst_o[0] !== 1'b0) begin errors++; $display("FAIL ram_rst got=%b exp=0", ram_rst_o[0]); end
        @(negedge clk); rst_n = 1'b1;
        // Start a transfer and pull reset right after word 2 lands on the port.
        @(negedge clk); start_vec[0] = 1'b1;
        @(negedge clk); start_vec[0] = 1'b0; wr_valid = 1'b1; wr_data = 32'hA0;
        @(negedge clk); wr_data = 32'hA1;
        @(negedge clk); wr_data = 32'hA2;
        @(posedge clk); #2;
        checks++; if (en_o[0] !== 1'b1 || addr_o[0] !== BASE_A + 32'h8) begin
            errors++; $display("FAIL pre_reset_word2 got en=%b addr=%h exp en=1 addr=%h", en_o[0], addr_o[0], BASE_A + 32'h8);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (en_o[0] !== 1'b0 || we_o[0] !== 4'h0 || addr_o[0] !== 32'h0 || wd_o[0] !== 32'h0) begin
            errors++; $display("FAIL async_reset_port got en=%b we=%h addr=%h wd=%h exp all 0", en_o[0], we_o[0], addr_o[0], wd_o[0]);
        end
        checks++; if (busy_o[0] !== 1'b0 || ready_o[0] !== 1'b0 || done_o[0] !== 1'b0) begin
            errors++; $display("FAIL async_reset_status got busy=%b ready=%b done=%b exp 0", busy_o[0], ready_o[0], done_o[0]);
        end
        n0 = obs_q.size();
        @(negedge clk); wr_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (obs_q.size() != n0) begin
            errors++; $display("FAIL reset_no_flag got writes=%0d exp=0", obs_q.size() - n0);
        end
        obs_rd = obs_q.size();
        exp_q.delete();
        drive_transfer(4, BASE_A, FLAG_A, 8'hB0, 1'b0, 1'b0, s, last, das);
        dcyc = -1;
        for (int t = 0; t < 20; t++) begin
            if (done_o[sel] === 1'b1) begin dcyc = cyc; break; end
            @(negedge clk);
        end
        checks++; if (dcyc != s + 6) begin errors++; $display("FAIL reset_rerun_done got=%0d exp=%0d", dcyc, s + 6); end
        #1;
        checks++; if (exp_q.size() != obs_q.size() - obs_rd) begin
            errors++; $display("FAIL reset_rerun_count got=%0d exp=%0d", obs_q.size() - obs_rd, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && obs_rd + i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[obs_rd+i].addr !== exp_q[i].addr || obs_q[obs_rd+i].data !== exp_q[i].data ||
                obs_q[obs_rd+i].we !== exp_q[i].we || obs_q[obs_rd+i].cyc != exp_q[i].cyc) begin
                errors++; $display("FAIL reset_rerun_wr%0d got a=%h d=%h we=%h c=%0d exp a=%h d=%h we=%h c=%0d", i,
                    obs_q[obs_rd+i].addr, obs_q[obs_rd+i].data, obs_q[obs_rd+i].we, obs_q[obs_rd+i].cyc,
                    exp_q[i].addr, exp_q[i].data, exp_q[i].we, exp_q[i].cyc);
            end
        end
        obs_rd = obs_q.size(); exp_q.delete();
        $display("test_reset done: errors=%0d", errors);
    endtask

    task automatic test_basic();
        int s, last, dcyc;
        logic das;
        sel = 0;
        drive_transfer(4, BASE_A, FLAG_A, 8'hA0, 1'b0, 1'b0, s, last, das);
        checks++; if (busy_o[0] !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", busy_o[0]); end
        dcyc = -1;
        for (int t = 0; t < 20; t++) begin
            if (done_o[sel] === 1'b1) begin dcyc = cyc; break; end
            @(negedge clk);
        end
        checks++; if (dcyc != s + 6) begin errors++; $display("FAIL basic_done_latency got=%0d exp=%0d", dcyc, s + 6); end
        #1;
        checks++; if (exp_q.size() != obs_q.size() - obs_rd) begin
            errors++; $display("FAIL basic_count got=%0d exp=%0d", obs_q.size() - obs_rd, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && obs_rd + i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[obs_rd+i].addr !== exp_q[i].addr || obs_q[obs_rd+i].data !== exp_q[i].data ||
                obs_q[obs_rd+i].we !== exp_q[i].we || obs_q[obs_rd+i].cyc != exp_q[i].cyc) begin
                errors++; $display("FAIL basic_wr%0d got a=%h d=%h c=%0d exp a=%h d=%h c=%0d", i,
                    obs_q[obs_rd+i].addr, obs_q[obs_rd+i].data, obs_q[obs_rd+i].cyc,
                    exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
            end
        end
        obs_rd = obs_q.size(); exp_q.delete();
        repeat (3) @(negedge clk);
        checks++; if (done_o[0] !== 1'b1 || busy_o[0] !== 1'b0 || en_o[0] !== 1'b0) begin
            errors++; $display("FAIL basic_done_hold got done=%b busy=%b en=%b exp 1 0 0", done_o[0], busy_o[0], en_o[0]);
        end
        $display("test_basic done: errors=%0d", errors);
    endtask

    task automatic test_backpressure();
        int s, last, dcyc, bw0;
        logic das;
        sel = 0;
        bw0 = bad_we;
        drive_transfer(4, BASE_A, FLAG_A, 8'hC0, 1'b1, 1'b0, s, last, das);
        dcyc = -1;
        for (int t = 0; t < 20; t++) begin
            if (done_o[sel] === 1'b1) begin dcyc = cyc; break; end
            @(negedge clk);
        end
        checks++; if (dcyc != last + 2) begin errors++; $display("FAIL bp_done got=%0d exp=%0d", dcyc, last + 2); end
        #1;
        checks++; if (bad_we != bw0) begin errors++; $display("FAIL bp_gap_we got=%0d exp=0", bad_we - bw0); end
        checks++; if (exp_q.size() != obs_q.size() - obs_rd) begin
            errors++; $display("FAIL bp_count got=%0d exp=%0d", obs_q.size() - obs_rd, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && obs_rd + i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[obs_rd+i].addr !== exp_q[i].addr || obs_q[obs_rd+i].data !== exp_q[i].data ||
                obs_q[obs_rd+i].we !== exp_q[i].we || obs_q[obs_rd+i].cyc != exp_q[i].cyc) begin
                errors++; $display("FAIL bp_wr%0d got a=%h d=%h c=%0d exp a=%h d=%h c=%0d", i,
                    obs_q[obs_rd+i].addr, obs_q[obs_rd+i].data, obs_q[obs_rd+i].cyc,
                    exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
            end
        end
        obs_rd = obs_q.size(); exp_q.delete();
        $display("test_backpressure done: errors=%0d", errors);
    endtask

    task automatic test_start_while_busy();
        int s, last, dcyc;
        logic das;
        sel = 0;
        for (int pass = 0; pass < 2; pass++) begin
            // Pass 0 holds start high through the whole transfer; pass 1 restarts from DONE.
            drive_transfer(4, BASE_A, FLAG_A, 8'hD0, 1'b0, (pass == 0), s, last, das);
            if (pass == 1) begin
                checks++; if (das !== 1'b0) begin errors++; $display("FAIL restart_done_drop got=%b exp=0", das); end
            end
            dcyc = -1;
            for (int t = 0; t < 20; t++) begin
                if (done_o[sel] === 1'b1) begin dcyc = cyc; break; end
                @(negedge clk);
            end
            checks++; if (dcyc != s + 6) begin errors++; $display("FAIL busy_start_done%0d got=%0d exp=%0d", pass, dcyc, s + 6); end
            repeat (2) @(negedge clk);
            checks++; if (exp_q.size() != obs_q.size() - obs_rd) begin
                errors++; $display("FAIL busy_start_count%0d got=%0d exp=%0d", pass, obs_q.size() - obs_rd, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && obs_rd + i < obs_q.size(); i++) begin
                checks++;
                if (obs_q[obs_rd+i].addr !== exp_q[i].addr || obs_q[obs_rd+i].data !== exp_q[i].data ||
                    obs_q[obs_rd+i].we !== exp_q[i].we || obs_q[obs_rd+i].cyc != exp_q[i].cyc) begin
                    errors++; $display("FAIL busy_start%0d_wr%0d got a=%h d=%h c=%0d exp a=%h d=%h c=%0d", pass, i,
                        obs_q[obs_rd+i].addr, obs_q[obs_rd+i].data, obs_q[obs_rd+i].cyc,
                        exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
                end
            end
            obs_rd = obs_q.size(); exp_q.delete();
        end
        $display("test_start_while_busy done: errors=%0d", errors);
    endtask

    task automatic test_single();
        int s, last, dcyc;
        logic das;
        sel = 1;
        drive_transfer(1, BASE_A, FLAG_B, 8'h11, 1'b0, 1'b0, s, last, das);
        dcyc = -1;
        for (int t = 0; t < 20; t++) begin
            if (done_o[sel] === 1'b1) begin dcyc = cyc; break; end
            @(negedge clk);
        end
        checks++; if (dcyc != s + 3) begin errors++; $display("FAIL single_done got=%0d exp=%0d", dcyc, s + 3); end
        #1;
        checks++; if (exp_q.size() != obs_q.size() - obs_rd) begin
            errors++; $display("FAIL single_count got=%0d exp=%0d", obs_q.size() - obs_rd, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && obs_rd + i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[obs_rd+i].addr !== exp_q[i].addr || obs_q[obs_rd+i].data !== exp_q[i].data ||
                obs_q[obs_rd+i].we !== exp_q[i].we || obs_q[obs_rd+i].cyc != exp_q[i].cyc) begin
                errors++; $display("FAIL single_wr%0d got a=%h d=%h c=%0d exp a=%h d=%h c=%0d", i,
                    obs_q[obs_rd+i].addr, obs_q[obs_rd+i].data, obs_q[obs_rd+i].cyc,
                    exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
            end
        end
        obs_rd = obs_q.size(); exp_q.delete();
        $display("test_single done: errors=%0d", errors);
    endtask

    task automatic test_wrap();
        int s, last, dcyc;
        logic das;
        sel = 2;
        drive_transfer(2, BASE_W, FLAG_B, 8'h70, 1'b0, 1'b0, s, last, das);
        dcyc = -1;
        for (int t = 0; t < 20; t++) begin
            if (done_o[sel] === 1'b1) begin dcyc = cyc; break; end
            @(negedge clk);
        end
        checks++; if (dcyc != s + 4) begin errors++; $display("FAIL wrap_done got=%0d exp=%0d", dcyc, s + 4); end
        #1;
        checks++; if (exp_q.size() != obs_q.size() - obs_rd) begin
            errors++; $display("FAIL wrap_count got=%0d exp=%0d", obs_q.size() - obs_rd, exp_q.size());
        end
        checks++; if (exp_q.size() != 3 || exp_q[2].addr !== 32'h0000_0000) begin
            errors++; $display("FAIL wrap_model got flag addr mismatch exp=00000000");
        end
        for (int i = 0; i < exp_q.size() && obs_rd + i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[obs_rd+i].addr !== exp_q[i].addr || obs_q[obs_rd+i].data !== exp_q[i].data ||
                obs_q[obs_rd+i].we !== exp_q[i].we || obs_q[obs_rd+i].cyc != exp_q[i].cyc) begin
                errors++; $display("FAIL wrap_wr%0d got a=%h d=%h c=%0d exp a=%h d=%h c=%0d", i,
                    obs_q[obs_rd+i].addr, obs_q[obs_rd+i].data, obs_q[obs_rd+i].cyc,
                    exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
            end
        end
        obs_rd = obs_q.size(); exp_q.delete();
        $display("test_wrap done: errors=%0d", errors);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_start_while_busy();
        test_single();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
